// File: rtl/pll_rst_seq_pkg.sv
// pll_rst_seq_pkg: sequencer state encoding and counter sizing helper.
package pll_rst_seq_pkg;
  typedef enum logic [2:0] {S_RESET, S_WAIT_LOCK, S_STABLE, S_RUN, S_FAIL} state_t;
  function automatic int cnt_width(input int a, input int b, input int c);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    return (m < 2) ? 1 : $clog2(m);
  endfunction
endpackage

// File: rtl/pll_lock_sync.sv
// pll_lock_sync: 2-flop synchronizer, async active-high reset to 0.
module pll_lock_sync (
  input  logic clk,
  input  logic rst,
  input  logic d_i,
  output logic q_o
);
  logic [1:0] sync_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[0], d_i};
  assign q_o = sync_q[1];
endmodule

// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: PLL reset / lock-qualify / sys_rst release sequencer.
// Define PLL_RST_SEQ_AUTO_RELOCK_EN to re-sequence on lock loss instead of failing.
module pll_reset_sequencer
  import pll_rst_seq_pkg::*;
#(
  parameter int PLL_RST_CYCLES = 16,
  parameter int LOCK_TIMEOUT   = 50000,
  parameter int LOCK_STABLE    = 1024,
  parameter int RETRY_MAX      = 3
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] loss_count
);
  localparam int CW = cnt_width(PLL_RST_CYCLES, LOCK_TIMEOUT, LOCK_STABLE);
  localparam int RW = (RETRY_MAX < 1) ? 1 : $clog2(RETRY_MAX + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [RW-1:0] retry_q, retry_d;
  logic [7:0]    loss_q, loss_d;
  logic          pll_rst_q, sys_rst_q, ready_q, fail_q;
  logic          locked_s;

  pll_lock_sync u_sync (.clk(refclk), .rst(rst), .d_i(locked), .q_o(locked_s));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + CW'(1);
    retry_d = retry_q;
    loss_d  = loss_q;
    case (state_q)
      S_RESET:
        if (cnt_q == CW'(PLL_RST_CYCLES - 1)) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end
      S_WAIT_LOCK:
        if (locked_s) begin
          state_d = S_STABLE;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_TIMEOUT - 1)) begin
          cnt_d   = '0;
          state_d = (retry_q == RW'(RETRY_MAX)) ? S_FAIL : S_RESET;
          retry_d = (retry_q == RW'(RETRY_MAX)) ? retry_q : retry_q + RW'(1);
        end
      S_STABLE:
        if (!locked_s) begin
          state_d = S_WAIT_LOCK;
          cnt_d   = '0;
        end else if (cnt_q == CW'(LOCK_STABLE - 1)) begin
          state_d = S_RUN;
          cnt_d   = '0;
          retry_d = '0;
        end
      S_RUN: begin
        cnt_d = '0;
        if (!locked_s) begin
          loss_d = loss_q + 8'(loss_q != 8'hff);
`ifdef PLL_RST_SEQ_AUTO_RELOCK_EN
          state_d = S_RESET;
          retry_d = '0;
`else
          state_d = S_FAIL;
`endif
        end
      end
      default: begin
        state_d = S_FAIL;
        cnt_d   = '0;
      end
    endcase
  end

  // outputs are flops loaded from the next state so they never glitch
  always_ff @(posedge refclk or posedge rst)
    if (rst) begin
      state_q   <= S_RESET;
      cnt_q     <= '0;
      retry_q   <= '0;
      loss_q    <= '0;
      pll_rst_q <= 1'b1;
      sys_rst_q <= 1'b1;
      ready_q   <= 1'b0;
      fail_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      retry_q   <= retry_d;
      loss_q    <= loss_d;
      pll_rst_q <= (state_d == S_RESET) || (state_d == S_FAIL);
      sys_rst_q <= state_d != S_RUN;
      ready_q   <= state_d == S_RUN;
      fail_q    <= state_d == S_FAIL;
    end

  assign pll_rst    = pll_rst_q;
  assign sys_rst    = sys_rst_q;
  assign ready      = ready_q;
  assign fail       = fail_q;
  assign loss_count = loss_q;
endmodule
